alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Shares one combinational `alu` instance between two requesters: port 0 is the integer execute stage, port 1 is the address-generation / branch-compare unit.
- Round-robin arbitration, valid/ready handshakes on both the request and response sides.
- Each operation is sequenced through a 3-state FSM; operands and result are registered, so the ALU sees stable inputs for one full cycle.
- Sits between the issue logic and the ALU in the CPU datapath.

Parameters:
- XLEN, 32, operand/result width.
- PRIO_RESET, 0, requester holding priority after reset (0 or 1).

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort of the in-flight op.
- req_valid  input  2  request valid per requester; bit i = requester i.
- req_ready  output  2  request accepted when valid&ready.
- req_in1  input  2*XLEN  operand A; requester i at [i*XLEN +: XLEN].
- req_in2  input  2*XLEN  operand B, same packing.
- req_func3  input  6  func3 per requester, 3 bits each.
- req_func7  input  14  func7 per requester, 7 bits each.
- rsp_valid  output  2  response valid; only the owning bit is set.
- rsp_ready  input  2  response consumed when valid&ready.
- rsp_result  output  XLEN  shared result bus.
- rsp_flags  output  4  {sign, overflow, cout, zero}.
- alu_in1  output  XLEN  to ALU in1.
- alu_in2  output  XLEN  to ALU in2.
- alu_func3  output  3  to ALU func3.
- alu_func7  output  7  to ALU func7.
- alu_C  input  XLEN  ALU result.
- alu_zero, alu_cout, alu_overflow, alu_sign  input  1 each  ALU flags.
- perf_grant0, perf_grant1  output  16 each  grant counters (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, prio=PRIO_RESET, owner=0.
  - req_ready=0, rsp_valid=0, rsp_result=0, rsp_flags=0.
  - alu_in1/in2/func3/func7 = 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is combinational. Only one valid requester: it is granted. Both valid: requester `prio` is granted. None valid: no grant.
  - req_ready = granted bit only, and only in IDLE; all other states drive req_ready=2'b00.
  - On the handshake edge: latch that requester's operands into the alu_* registers, set owner=i, set prio=~i, go to EXEC.
- EXEC (exactly 1 cycle):
  - ALU inputs are stable.
  - At the end of the cycle, capture alu_C into rsp_result and the flags into rsp_flags, go to RESP.
- RESP:
  - rsp_valid[owner]=1.
  - rsp_result and rsp_flags are held stable until rsp_ready[owner]=1, then go to IDLE.
  - rsp_ready on the non-owner bit is ignored.
- Latency and throughput:
  - Request accepted at edge T; rsp_valid is high from cycle T+2.
  - Minimum 3 cycles per op; no new grant during EXEC or RESP.
- alu_* outputs keep the last operands after an op; they are not zeroed.
- flush:
  - Takes priority over everything.
  - In EXEC or RESP: next state IDLE, rsp_valid cleared, no response delivered, prio unchanged.
  - In IDLE: a pending request is not accepted that cycle (req_ready forced to 0).
- Starvation: under continuous dual requests, grants strictly alternate 0,1,0,1…
- Widths: flags and result are passed through untouched; no arithmetic is performed here.

Optional Feature:
- Macro: ALU_SHARE_PERF_CNT_EN.
- Defined:
  - perf_grant0/perf_grant1 count accepted requests per requester.
  - 16-bit counters, saturating at 16'hFFFF.
  - Cleared by rst_n only; flush does not clear them, and an op counts even if later flushed.
- Undefined: counters are not built and perf_grant0/1 are tied to 16'h0000.

Test Plan:
- Single op: req_valid=01, in1=1, in2=2, func3=000, func7=0, ALU model returns 3 -> req_ready[0] at T; alu_in1=1, alu_in2=2 at T+1; rsp_valid=01, rsp_result=0x3, zero=0 at T+2.
- Contention: req_valid=11 held for 4 ops, prio=0 after reset -> grant order 0,1,0,1; each rsp_valid bit goes to the correct owner; results tagged correctly (req0 in1<<in2 with 1,5 = 0x20; req1 add with 7,9 = 0x10).
- Backpressure: rsp_ready[owner]=0 for 5 cycles -> rsp_valid, result and flags held stable; req_ready stays 00; state returns to IDLE one cycle after rsp_ready=1.
- Flush in EXEC: accept op from requester 1, assert flush the next cycle -> no rsp_valid ever; IDLE next cycle; prio=0.
- Async reset in RESP: drop rsp_n mid-cycle with rsp_valid=10 -> all outputs zero immediately, before the next clock edge; after release, single op works with prio=PRIO_RESET.
- Perf counters (macro defined): 3 grants to requester 0 and 2 to requester 1 -> perf_grant0=3, perf_grant1=2. With the macro undefined, both read 0.

Source files
------------

// File: rtl/alu_share_if.sv
// -----------------------------------------------------------------------------
// alu_share_if
// Request/response bus between two requesters and the shared-ALU arbiter.
//
// Request side (per requester i, packed at [i*W +: W]):
//   req_valid[1:0]  requester -> arbiter  operation offered
//   req_ready[1:0]  arbiter -> requester  operation accepted when valid&ready
//   req_in1/in2     requester -> arbiter  operands, XLEN bits each
//   req_func3       requester -> arbiter  3 bits per requester
//   req_func7       requester -> arbiter  7 bits per requester
// Response side:
//   rsp_valid[1:0]  arbiter -> requester  only the owning bit is ever set
//   rsp_ready[1:0]  requester -> arbiter  response consumed when valid&ready
//   rsp_result      arbiter -> requester  shared result bus
//   rsp_flags       arbiter -> requester  {sign, overflow, cout, zero}
//
// master modport: the requester side. slave modport: the arbiter.
// -----------------------------------------------------------------------------
interface alu_share_if #(
    parameter int XLEN = 32
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [2*XLEN-1:0] req_in1;
    logic [2*XLEN-1:0] req_in2;
    logic [5:0]        req_func3;
    logic [13:0]       req_func7;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [XLEN-1:0]   rsp_result;
    logic [3:0]        rsp_flags;

    modport master (
        output req_valid, req_in1, req_in2, req_func3, req_func7, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_flags
    );

    modport slave (
        input  req_valid, req_in1, req_in2, req_func3, req_func7, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one combinational ALU between two requesters (0: integer execute,
// 1: address-generation / branch compare). Round-robin arbitration, a
// three-state IDLE -> EXEC -> RESP sequence per operation, registered
// operands toward the ALU and a registered result/flags toward the owner.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   flush          synchronous abort of the in-flight operation
//   bus            alu_share_if.slave request/response bus
//   alu_in1/in2    registered operands to the ALU
//   alu_func3/7    registered function select to the ALU
//   alu_C          ALU result
//   alu_zero/cout/overflow/sign  ALU flags
//   perf_grant0/1  accepted-request counters per requester
//
// Parameters:
//   XLEN        operand/result width
//   PRIO_RESET  requester holding priority after reset
//
// Optional feature macro: ALU_SHARE_PERF_CNT_EN
//   defined   -> 16-bit saturating grant counters, cleared only by rst_n
//   undefined -> perf_grant0/1 tied to zero
// -----------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int XLEN       = 32,
    parameter bit PRIO_RESET = 1'b0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    alu_share_if.slave      bus,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [2:0]      alu_func3,
    output logic [6:0]      alu_func7,
    input  logic [XLEN-1:0] alu_C,
    input  logic            alu_zero,
    input  logic            alu_cout,
    input  logic            alu_overflow,
    input  logic            alu_sign,
    output logic [15:0]     perf_grant0,
    output logic [15:0]     perf_grant1
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            prio_q, prio_d;
    logic            owner_q, owner_d;
    logic [XLEN-1:0] in1_q, in1_d;
    logic [XLEN-1:0] in2_q, in2_d;
    logic [2:0]      func3_q, func3_d;
    logic [6:0]      func7_q, func7_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [3:0]      flags_q, flags_d;

    // Per-requester views of the packed request fields.
    logic [XLEN-1:0] op_a  [2];
    logic [XLEN-1:0] op_b  [2];
    logic [2:0]      op_f3 [2];
    logic [6:0]      op_f7 [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign op_a[gi]  = bus.req_in1[gi*XLEN +: XLEN];
            assign op_b[gi]  = bus.req_in2[gi*XLEN +: XLEN];
            assign op_f3[gi] = bus.req_func3[gi*3 +: 3];
            assign op_f7[gi] = bus.req_func7[gi*7 +: 7];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Combinational grant: a lone requester wins outright, a tie goes to
    // the requester currently holding priority.
    // ------------------------------------------------------------------
    logic grant_any;
    logic grant_idx;

    always_comb begin
        grant_any = 1'b0;
        grant_idx = prio_q;
        case (bus.req_valid)
            2'b01: begin
                grant_any = 1'b1;
                grant_idx = 1'b0;
            end
            2'b10: begin
                grant_any = 1'b1;
                grant_idx = 1'b1;
            end
            2'b11: begin
                grant_any = 1'b1;
                grant_idx = prio_q;
            end
            default: begin
                grant_any = 1'b0;
                grant_idx = prio_q;
            end
        endcase
    end

    // A handshake only happens in IDLE and never while flush is high.
    logic accept;
    assign accept = (state_q == ST_IDLE) && grant_any && !flush;

    // ------------------------------------------------------------------
    // Next-state and datapath register inputs.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        owner_d  = owner_q;
        in1_d    = in1_q;
        in2_d    = in2_q;
        func3_d  = func3_q;
        func7_d  = func7_q;
        result_d = result_q;
        flags_d  = flags_q;

        if (flush) begin
            // Abort whatever is in flight; priority is left untouched so a
            // flushed op does not cost the other requester its turn.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        in1_d   = op_a[grant_idx];
                        in2_d   = op_b[grant_idx];
                        func3_d = op_f3[grant_idx];
                        func7_d = op_f7[grant_idx];
                        owner_d = grant_idx;
                        prio_d  = ~grant_idx;
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // ALU inputs have been stable for the whole cycle.
                    result_d = alu_C;
                    flags_d  = {alu_sign, alu_overflow, alu_cout, alu_zero};
                    state_d  = ST_RESP;
                end
                ST_RESP: begin
                    // Only the owner's ready bit can retire the response.
                    if (bus.rsp_ready[owner_q]) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            prio_q   <= PRIO_RESET;
            owner_q  <= 1'b0;
            in1_q    <= '0;
            in2_q    <= '0;
            func3_q  <= '0;
            func7_q  <= '0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            owner_q  <= owner_d;
            in1_q    <= in1_d;
            in2_q    <= in2_d;
            func3_q  <= func3_d;
            func7_q  <= func7_d;
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs. req_ready is gated with rst_n so it reads zero while reset
    // is held even though the grant logic itself is combinational.
    // ------------------------------------------------------------------
    assign bus.req_ready  = (accept && rst_n) ? (2'b01 << grant_idx) : 2'b00;
    assign bus.rsp_valid  = (state_q == ST_RESP) ? (2'b01 << owner_q) : 2'b00;
    assign bus.rsp_result = result_q;
    assign bus.rsp_flags  = flags_q;

    assign alu_in1   = in1_q;
    assign alu_in2   = in2_q;
    assign alu_func3 = func3_q;
    assign alu_func7 = func7_q;

    // ------------------------------------------------------------------
    // Optional grant counters.
    // ------------------------------------------------------------------
`ifdef ALU_SHARE_PERF_CNT_EN
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [15:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                // Counts at acceptance, so an op flushed later still counts.
                if (accept && (grant_idx == gi[0]) && (cnt_q != 16'hFFFF)) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

    assign perf_grant0 = g_cnt[0].cnt_q;
    assign perf_grant1 = g_cnt[1].cnt_q;
`else
    assign perf_grant0 = 16'h0000;
    assign perf_grant1 = 16'h0000;
`endif

    // ------------------------------------------------------------------
    // Structural invariants.
    // ------------------------------------------------------------------
    a_req_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.req_ready));
    a_rsp_valid_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(bus.rsp_valid));
    a_no_grant_busy: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q != ST_IDLE) |-> (bus.req_ready == 2'b00));

endmodule

// File: tb/tb_alu_share_arbiter.sv
module tb_alu_share_arbiter;

    localparam int XLEN = 32;

    logic            clk;
    logic            rst_n;
    logic            flush;
    logic [XLEN-1:0] alu_in1, alu_in2, alu_C;
    logic [2:0]      alu_func3;
    logic [6:0]      alu_func7;
    logic            alu_zero, alu_cout, alu_overflow, alu_sign;
    logic [15:0]     perf_grant0, perf_grant1;

    int checks = 0;
    int errors = 0;

    alu_share_if #(.XLEN(XLEN)) bus ();

    alu_share_arbiter #(.XLEN(XLEN), .PRIO_RESET(1'b0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .alu_in1      (alu_in1),
        .alu_in2      (alu_in2),
        .alu_func3    (alu_func3),
        .alu_func7    (alu_func7),
        .alu_C        (alu_C),
        .alu_zero     (alu_zero),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .alu_sign     (alu_sign),
        .perf_grant0  (perf_grant0),
        .perf_grant1  (perf_grant1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small RISC-V-like ALU model driven by the arbiter's registered outputs.
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   add_full;
    always_comb begin
        b_eff        = alu_func7[5] ? ~alu_in2 : alu_in2;
        add_full     = {1'b0, alu_in1} + {1'b0, b_eff} + {{XLEN{1'b0}}, alu_func7[5]};
        alu_C        = '0;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_func3)
            3'b000: begin
                alu_C        = add_full[XLEN-1:0];
                alu_cout     = add_full[XLEN];
                alu_overflow = (alu_in1[XLEN-1] == b_eff[XLEN-1]) &&
                               (add_full[XLEN-1] != alu_in1[XLEN-1]);
            end
            3'b001:  alu_C = alu_in1 << alu_in2[4:0];
            3'b100:  alu_C = alu_in1 ^ alu_in2;
            3'b110:  alu_C = alu_in1 | alu_in2;
            3'b111:  alu_C = alu_in1 & alu_in2;
            default: alu_C = '0;
        endcase
        alu_zero = (alu_C == '0);
        alu_sign = alu_C[XLEN-1];
    end

    task automatic clear_inputs();
        bus.req_valid = 2'b00;
        bus.req_in1   = '0;
        bus.req_in2   = '0;
        bus.req_func3 = '0;
        bus.req_func7 = '0;
        bus.rsp_ready = 2'b00;
        flush         = 1'b0;
    endtask

    // Returns just after a falling edge with reset released.
    task automatic apply_reset();
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 1'b0;
        bus.req_valid = 2'b11;
        #3;
        checks++;
        if (bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL reset_req_ready got=%b want=00", bus.req_ready);
        end
        checks++;
        if (bus.rsp_valid !== 2'b00 || bus.rsp_result !== '0 || bus.rsp_flags !== 4'h0) begin
            errors++;
            $display("FAIL reset_rsp got valid=%b result=%h flags=%b want 00/0/0000",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
        end
        checks++;
        if (alu_in1 !== '0 || alu_in2 !== '0 || alu_func3 !== 3'd0 || alu_func7 !== 7'd0) begin
            errors++;
            $display("FAIL reset_alu got in1=%h in2=%h f3=%h f7=%h want zeros",
                     alu_in1, alu_in2, alu_func3, alu_func7);
        end
        $display("txn reset: outputs checked with rst_n low");
        apply_reset();
    endtask

    task automatic test_single_op();
        apply_reset();
        bus.req_valid = 2'b01;
        bus.req_in1   = {32'd0, 32'd1};
        bus.req_in2   = {32'd0, 32'd2};
        bus.rsp_ready = 2'b01;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL single_req_ready got=%b want=01", bus.req_ready);
        end
        @(negedge clk); #1;
        bus.req_valid = 2'b00;
        checks++;
        if (alu_in1 !== 32'd1 || alu_in2 !== 32'd2 || bus.req_ready !== 2'b00 || bus.rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL single_exec got in1=%h in2=%h rdy=%b vld=%b want 1/2/00/00",
                     alu_in1, alu_in2, bus.req_ready, bus.rsp_valid);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'h3 || bus.rsp_flags !== 4'b0000) begin
            errors++;
            $display("FAIL single_resp got vld=%b res=%h flags=%b want 01/3/0000",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
        end
        @(negedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 2'b00) begin
            errors++;
            $display("FAIL single_done got vld=%b want=00", bus.rsp_valid);
        end
        $display("txn single: req0 1+2 -> %h", bus.rsp_result);
    endtask

    task automatic test_contention();
        logic [1:0]      exp_bit;
        logic [XLEN-1:0] exp_in1, exp_res;
        apply_reset();
        bus.req_in1   = {32'd7, 32'd1};
        bus.req_in2   = {32'd9, 32'd5};
        bus.req_func3 = {3'b000, 3'b001};
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            exp_bit = (k % 2 == 0) ? 2'b01 : 2'b10;
            exp_in1 = (k % 2 == 0) ? 32'd1 : 32'd7;
            exp_res = (k % 2 == 0) ? 32'h20 : 32'h10;
            #1;
            checks++;
            if (bus.req_ready !== exp_bit) begin
                errors++;
                $display("FAIL contention_grant op=%0d got=%b want=%b", k, bus.req_ready, exp_bit);
            end
            @(negedge clk); #1;
            checks++;
            if (alu_in1 !== exp_in1) begin
                errors++;
                $display("FAIL contention_operand op=%0d got=%h want=%h", k, alu_in1, exp_in1);
            end
            @(negedge clk); #1;
            checks++;
            if (bus.rsp_valid !== exp_bit || bus.rsp_result !== exp_res) begin
                errors++;
                $display("FAIL contention_resp op=%0d got vld=%b res=%h want %b/%h",
                         k, bus.rsp_valid, bus.rsp_result, exp_bit, exp_res);
            end
            $display("txn contention op=%0d owner=%b result=%h", k, bus.rsp_valid, bus.rsp_result);
            @(negedge clk);
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_backpressure();
        apply_reset();
        bus.req_valid = 2'b01;
        bus.req_in1   = {32'd0, 32'd5};
        bus.req_in2   = {32'd0, 32'd5};
        bus.req_func7 = {7'd0, 7'h20};
        bus.rsp_ready = 2'b00;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL bp_grant got=%b want=01", bus.req_ready);
        end
        @(negedge clk); #1;
        bus.req_valid = 2'b11;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            bus.rsp_ready = 2'b10;
            checks++;
            if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'h0 ||
                bus.rsp_flags !== 4'b0011 || bus.req_ready !== 2'b00) begin
                errors++;
                $display("FAIL bp_hold cyc=%0d got vld=%b res=%h flags=%b rdy=%b want 01/0/0011/00",
                         c, bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.req_ready);
            end
            $display("txn backpressure cyc=%0d vld=%b flags=%b", c, bus.rsp_valid, bus.rsp_flags);
        end
        bus.rsp_ready = 2'b01;
        @(negedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 2'b00 || bus.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL bp_release got vld=%b rdy=%b want 00/10", bus.rsp_valid, bus.req_ready);
        end
        bus.req_valid = 2'b00;
    endtask

    task automatic test_flush();
        apply_reset();
        bus.req_valid = 2'b10;
        bus.req_in1   = {32'd3, 32'd0};
        bus.req_in2   = {32'd4, 32'd0};
        bus.rsp_ready = 2'b11;
        #1;
        checks++;
        if (bus.req_ready !== 2'b10) begin
            errors++;
            $display("FAIL flush_grant got=%b want=10", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 2'b00;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++;
            if (bus.rsp_valid !== 2'b00) begin
                errors++;
                $display("FAIL flush_no_rsp cyc=%0d got=%b want=00", c, bus.rsp_valid);
            end
            @(negedge clk);
        end
        bus.req_valid = 2'b11;
        flush = 1'b1;
        #1;
        checks++;
        if (bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL flush_idle_block got=%b want=00", bus.req_ready);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL flush_prio got=%b want=01", bus.req_ready);
        end
        bus.req_valid = 2'b00;
        $display("txn flush: exec op from req1 aborted, prio kept at 0");
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.req_valid = 2'b10;
        bus.req_in1   = {32'h0000AAAA, 32'd0};
        bus.req_in2   = {32'h00000001, 32'd0};
        bus.req_func3 = {3'b110, 3'b000};
        bus.rsp_ready = 2'b00;
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 2'b10 || bus.rsp_result !== 32'h0000AAAB) begin
            errors++;
            $display("FAIL areset_pre got vld=%b res=%h want 10/0000aaab", bus.rsp_valid, bus.rsp_result);
        end
        bus.req_valid = 2'b11;
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.rsp_valid !== 2'b00 || bus.rsp_result !== '0 || bus.rsp_flags !== 4'h0 ||
            bus.req_ready !== 2'b00) begin
            errors++;
            $display("FAIL areset_rsp got vld=%b res=%h flags=%b rdy=%b want zeros",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_flags, bus.req_ready);
        end
        checks++;
        if (alu_in1 !== '0 || alu_in2 !== '0 || alu_func3 !== 3'd0 || alu_func7 !== 7'd0) begin
            errors++;
            $display("FAIL areset_alu got in1=%h in2=%h f3=%h f7=%h want zeros",
                     alu_in1, alu_in2, alu_func3, alu_func7);
        end
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_in1   = {32'd0, 32'h7FFFFFFF};
        bus.req_in2   = {32'd0, 32'h00000001};
        bus.req_func3 = 6'd0;
        bus.rsp_ready = 2'b01;
        #1;
        checks++;
        if (bus.req_ready !== 2'b01) begin
            errors++;
            $display("FAIL areset_prio got=%b want=01", bus.req_ready);
        end
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk); #1;
        checks++;
        if (bus.rsp_valid !== 2'b01 || bus.rsp_result !== 32'h80000000 || bus.rsp_flags !== 4'b1100) begin
            errors++;
            $display("FAIL areset_op got vld=%b res=%h flags=%b want 01/80000000/1100",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_flags);
        end
        $display("txn async_reset: op after release result=%h", bus.rsp_result);
        @(negedge clk);
    endtask

    task automatic test_perf();
        apply_reset();
        bus.req_in1   = {32'd2, 32'd1};
        bus.req_in2   = {32'd2, 32'd1};
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 4) bus.req_valid = 2'b00;
            @(negedge clk);
            @(negedge clk);
        end
        #1;
        checks++;
`ifdef ALU_SHARE_PERF_CNT_EN
        if (perf_grant0 !== 16'd3 || perf_grant1 !== 16'd2) begin
            errors++;
            $display("FAIL perf_counts got g0=%0d g1=%0d want 3/2", perf_grant0, perf_grant1);
        end
`else
        if (perf_grant0 !== 16'd0 || perf_grant1 !== 16'd0) begin
            errors++;
            $display("FAIL perf_counts got g0=%0d g1=%0d want 0/0", perf_grant0, perf_grant1);
        end
`endif
        $display("txn perf: g0=%0d g1=%0d", perf_grant0, perf_grant1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_op();
        test_contention();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
